cpu_ocimem_sequencer: RTL and testbench



---
 rtl/cpu_ocimem_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_ocimem_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ocimem_sequencer.sv
// cpu_ocimem_sequencer
// Arbitrates the single-port OCI debug RAM between the JTAG debug path
// (action strobes + jdo) and the CPU data master (Avalon slave). Also holds
// the JTAG-side monitor registers shifted back to the host.
// JTAG address field jdo[ADDR_W+16:17] requires ADDR_W <= 17.
module cpu_ocimem_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic [3:0]        ram_byteen,
  input  logic [31:0]       ram_q,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_JRD  = 2'd1,
    S_CRD  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e            state_q;
  logic              jpend_q;
  logic              jwr_q;
  logic [31:0]       jdata_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [31:0]       mon_d_q;
  logic              ready_q;
  logic              error_q;
  logic              last_j_q;   // 1: previous grant went to JTAG

  logic              cpu_req;
  logic              in_idle;
  logic              in_crd;
  logic              grant_j;
  logic              grant_c;
  logic              str_a;
  logic              str_n;
  logic              str_b;
  logic              any_str;
  logic              queue_req;
  logic [ADDR_W-1:0] mon_a_d;

  // jdo bits outside the address/data/read-flag fields carry nothing here
  logic              unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

  // Strobe decode: only one is expected per cycle; b > no_action_a > action_a
  always_comb begin
    str_b     = take_action_ocimem_b;
    str_n     = take_no_action_ocimem_a && !take_action_ocimem_b;
    str_a     = take_action_ocimem_a && !take_no_action_ocimem_a && !take_action_ocimem_b;
    any_str   = str_a || str_n || str_b;
    queue_req = str_b || str_n || (str_a && jdo[34]);
    mon_a_d   = mon_a_q + ADDR_ONE;
  end

  // Arbitration: JTAG has priority unless it won last time, so a contended
  // CPU waits for at most one JTAG access. Nothing is granted during reset.
  always_comb begin
    cpu_req = avs_read || avs_write;
    in_idle = (state_q == S_IDLE) && !reset;
    in_crd  = (state_q == S_CRD) && !reset;
    grant_j = in_idle && jpend_q && (!cpu_req || !last_j_q);
    grant_c = in_idle && cpu_req && (!jpend_q || last_j_q);
  end

  // RAM port and Avalon response, steered by the current grant
  always_comb begin
    ram_we          = (grant_j && jwr_q) || (grant_c && avs_write);
    ram_addr        = avs_address;
    ram_wdata       = avs_writedata;
    ram_byteen      = avs_byteenable;
    if (grant_j || (state_q == S_JRD)) begin
      ram_addr = mon_a_q;
    end
    if (grant_j) begin
      ram_wdata  = jdata_q;
      ram_byteen = 4'hF;
    end
    avs_readdata    = in_crd ? ram_q : 32'd0;
    avs_waitrequest = cpu_req && !((grant_c && avs_write) || (in_crd && avs_read));
  end

  // Sequencer FSM plus JTAG request/monitor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      jpend_q  <= 1'b0;
      jwr_q    <= 1'b0;
      jdata_q  <= 32'd0;
      mon_a_q  <= '0;
      mon_d_q  <= 32'd0;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
      last_j_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_j) begin
            last_j_q <= 1'b1;
            if (jwr_q) begin
              // Write retires in the grant cycle
              jpend_q <= 1'b0;
              mon_a_q <= mon_a_d;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_JRD;
            end
          end else if (grant_c) begin
            last_j_q <= 1'b0;
            if (!avs_write) begin
              state_q <= S_CRD;
            end
          end
        end
        S_JRD: begin
          mon_d_q <= ram_q;
          mon_a_q <= mon_a_d;
          jpend_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Completion above only happens with jpend_q=1, and strobes are only
      // accepted with jpend_q=0, so the two never update the same register
      // in the same cycle.
      if (str_a) begin
        error_q <= 1'b0;
      end
      if (any_str) begin
        if (jpend_q) begin
          error_q <= 1'b1;
        end else begin
          if (str_a) begin
            mon_a_q <= jdo[ADDR_W+16:17];
          end
          if (queue_req) begin
            jpend_q <= 1'b1;
            jwr_q   <= str_b;
            ready_q <= 1'b0;
            if (str_b) begin
              jdata_q <= jdo[34:3];
            end
          end
        end
      end
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_cpu_ocimem_sequencer.sv
// Testbench for cpu_ocimem_sequencer: behavioural RAM, write/read scoreboards,
// a table of JTAG/CPU operations and hand-written multi-cycle sequences.
module tb_cpu_ocimem_sequencer;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0;
  logic          tn_a = 1'b0;
  logic          tb_b = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [3:0]    avs_byteenable = '0;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic [3:0]    ram_byteen;
  logic [31:0]   ram_q;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;

  cpu_ocimem_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tn_a),
    .take_action_ocimem_b(tb_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_byteen(ram_byteen), .ram_q(ram_q),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         wq[$];   // expected RAM writes
  logic [31:0] cq[$];   // expected CPU read data
  logic [31:0] jq[$];   // expected JTAG read data
  logic [31:0] shadow [0:255];

  int n_tests = 0;
  int n_fail = 0;
  int wr_count = 0;
  bit contention = 1'b0;
  int wait_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] pass %s = %0h", name, act);
    end
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a; w.data = d; w.be = be;
    wq.push_back(w);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // RAM write scoreboard (unordered match), reset write guard, CPU read data, wait bound
  always @(negedge clk) begin : monitor
    int idx;
    if (reset) begin
      check("no_ram_we_in_reset", ram_we, 1'b0);
    end else begin
      if (ram_we) begin
        wr_count++;
        idx = -1;
        for (int i = 0; i < wq.size(); i++)
          if (idx < 0 && wq[i].addr == ram_addr && wq[i].data == ram_wdata && wq[i].be == ram_byteen)
            idx = i;
        n_tests++;
        if (idx < 0) begin
          n_fail++;
          $display("[TB] FAIL ram_write: got addr %0h data %0h be %0h, required a queued write",
                   ram_addr, ram_wdata, ram_byteen);
        end else begin
          wq.delete(idx);
          $display("[TB] pass ram_write addr %0h data %0h be %0h", ram_addr, ram_wdata, ram_byteen);
        end
      end
      if (avs_read && !avs_waitrequest) begin
        if (cq.size() == 0) check("cpu_read_unexpected", 1'b1, 1'b0);
        else check("cpu_rdata", avs_readdata, cq.pop_front());
      end
      if (contention) begin
        if (avs_write && avs_waitrequest) wait_run++;
        else wait_run = 0;
        check("cpu_wait_le1", (wait_run <= 1), 1'b1);
      end
    end
  end

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One-cycle strobe: 0 action_a, 1 no_action_a, 2 action_b. Enters/leaves at posedge+1.
  task automatic strobe(input int kind, input logic [37:0] j);
    jdo = j;
    ta_a = (kind == 0);
    tn_a = (kind == 1);
    tb_b = (kind == 2);
    @(posedge clk); #1;
    ta_a = 1'b0; tn_a = 1'b0; tb_b = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (monitor_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    check({name, "_ready_in_time"}, ok, 1'b1);
  endtask

  task automatic jwrite(input logic [7:0] exp_addr, input logic [31:0] d);
    expect_write(exp_addr, d, 4'hF);
    strobe(2, jdo_data(d));
    wait_ready("jwrite");
  endtask

  task automatic jread(input int kind, input logic [7:0] a, input logic [31:0] exp);
    jq.push_back(exp);
    strobe(kind, jdo_addr(a, kind == 0));
    wait_ready("jread");
    check("MonDReg", MonDReg, jq.pop_front());
  endtask

  // Leaves avs_write asserted so writes can be issued back to back
  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bit done;
    expect_write(a, d, be);
    avs_write = 1'b1; avs_address = a; avs_writedata = d; avs_byteenable = be;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !avs_waitrequest;
      @(posedge clk); #1;
    end
    check("cpu_write_done", done, 1'b1);
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
    bit done;
    cq.push_back(exp);
    avs_read = 1'b1; avs_address = a;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !avs_waitrequest;
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    check("cpu_read_done", done, 1'b1);
  endtask

  typedef struct {
    int          op;        // 0 J_ADDR, 1 J_ADDR_RD, 2 J_NRD, 3 J_WR, 4 C_WR, 5 C_RD
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic [7:0]  exp_mona;
  } vec_t;

  vec_t tbl [15];

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int wc0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end

    tbl[0]  = '{0, 8'hFF, 32'h0,        4'h0,    32'h0,        8'hFF};
    tbl[1]  = '{3, 8'hFF, 32'h12345678, 4'hF,    32'h0,        8'h00};
    tbl[2]  = '{0, 8'hFF, 32'h0,        4'h0,    32'h0,        8'hFF};
    tbl[3]  = '{2, 8'h00, 32'h0,        4'h0,    32'h12345678, 8'h00};
    tbl[4]  = '{3, 8'h00, 32'hA5A5A5A5, 4'hF,    32'h0,        8'h01};
    tbl[5]  = '{5, 8'h00, 32'h0,        4'h0,    32'hA5A5A5A5, 8'h01};
    tbl[6]  = '{4, 8'h07, 32'h11223344, 4'b0101, 32'h0,        8'h01};
    tbl[7]  = '{5, 8'h07, 32'h0,        4'h0,    32'h00220044, 8'h01};
    tbl[8]  = '{1, 8'h07, 32'h0,        4'h0,    32'h00220044, 8'h08};
    tbl[9]  = '{5, 8'h05, 32'h0,        4'h0,    32'hDEADBEEF, 8'h08};
    tbl[10] = '{4, 8'hFF, 32'hCAFEF00D, 4'hF,    32'h0,        8'h08};
    tbl[11] = '{1, 8'hFF, 32'h0,        4'h0,    32'hCAFEF00D, 8'h00};
    tbl[12] = '{4, 8'h09, 32'hFFFFFFFF, 4'b1000, 32'h0,        8'h00};
    tbl[13] = '{1, 8'h09, 32'h0,        4'h0,    32'hFF000000, 8'h0A};
    tbl[14] = '{2, 8'h00, 32'h0,        4'h0,    32'h00000000, 8'h0B};

    // Reset values
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_monitor_ready", monitor_ready, 1'b1);
    check("rst_monitor_error", monitor_error, 1'b0);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_waitrequest", avs_waitrequest, 1'b0);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_MonAReg", dut.mon_a_q, 8'h00);
    check("rst_jpend", dut.jpend_q, 1'b0);
    @(posedge clk); #1;

    // JTAG write latency: ram_we in T+1, monitor_ready from T+2
    strobe(0, jdo_addr(8'h05, 1'b0));
    check("seta_MonAReg", dut.mon_a_q, 8'h05);
    expect_write(8'h05, 32'hDEADBEEF, 4'hF);
    strobe(2, jdo_data(32'hDEADBEEF));
    @(negedge clk);
    check("jwr_T1_ram_we", ram_we, 1'b1);
    check("jwr_T1_ram_addr", ram_addr, 8'h05);
    check("jwr_T1_ready_low", monitor_ready, 1'b0);
    @(negedge clk);
    check("jwr_T2_ready", monitor_ready, 1'b1);
    check("jwr_T2_ram_we", ram_we, 1'b0);
    @(posedge clk); #1;
    check("jwr_MonAReg", dut.mon_a_q, 8'h06);

    // JTAG read latency: MonDReg and monitor_ready valid from T+3
    strobe(0, jdo_addr(8'h05, 1'b1));
    @(negedge clk);
    check("jrd_T1_ram_addr", ram_addr, 8'h05);
    check("jrd_T1_ready_low", monitor_ready, 1'b0);
    @(negedge clk);
    check("jrd_T2_ready_low", monitor_ready, 1'b0);
    check("jrd_T2_MonDReg_old", MonDReg, 32'h0);
    @(negedge clk);
    check("jrd_T3_ready", monitor_ready, 1'b1);
    check("jrd_T3_MonDReg", MonDReg, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("jrd_MonAReg", dut.mon_a_q, 8'h06);

    // Table of operations
    for (int v = 0; v < 15; v++) begin
      case (tbl[v].op)
        0: strobe(0, jdo_addr(tbl[v].addr, 1'b0));
        1: jread(0, tbl[v].addr, tbl[v].exp_data);
        2: jread(1, tbl[v].addr, tbl[v].exp_data);
        3: jwrite(tbl[v].addr, tbl[v].data);
        4: begin cpu_write(tbl[v].addr, tbl[v].data, tbl[v].be); avs_write = 1'b0; end
        default: cpu_read(tbl[v].addr, tbl[v].exp_data);
      endcase
      if (tbl[v].op <= 3) check($sformatf("vec%0d_MonAReg", v), dut.mon_a_q, tbl[v].exp_mona);
    end

    // Overrun: second write strobe lands while the first waits behind a CPU read
    strobe(0, jdo_addr(8'h60, 1'b0));
    wc0 = wr_count;
    expect_write(8'h60, 32'h00000B01, 4'hF);
    fork
      cpu_read(8'h00, shadow[0]);
      begin
        strobe(2, jdo_data(32'h00000B01));
        strobe(2, jdo_data(32'h00000B02));
      end
    join
    wait_ready("ovr");
    check("ovr_monitor_error", monitor_error, 1'b1);
    check("ovr_one_write", wr_count - wc0, 1);
    check("ovr_MonAReg", dut.mon_a_q, 8'h61);
    strobe(0, jdo_addr(8'h10, 1'b0));
    check("ovr_error_cleared", monitor_error, 1'b0);

    // Contention: CPU writes held continuously, JTAG writes back to back
    contention = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) cpu_write(8'h80 + 8'(i), 32'hC0DE0000 + i, 4'hF);
        avs_write = 1'b0;
      end
      begin
        strobe(0, jdo_addr(8'h40, 1'b0));
        for (int i = 0; i < 6; i++) jwrite(8'h40 + 8'(i), 32'h7A600000 + i);
      end
    join
    contention = 1'b0;
    check("cont_MonAReg", dut.mon_a_q, 8'h46);
    for (int i = 0; i < 6; i++) begin
      cpu_read(8'h40 + 8'(i), shadow[8'h40 + i]);
      cpu_read(8'h80 + 8'(i), shadow[8'h80 + i]);
    end

    // Reset during JRD: in-flight read abandoned, no write issued
    strobe(0, jdo_addr(8'h05, 1'b1));
    @(posedge clk); #1;
    check("jrd_inflight_jpend", dut.jpend_q, 1'b1);
    wc0 = wr_count;
    reset = 1'b1;
    avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h55555555; avs_byteenable = 4'hF;
    @(negedge clk);
    check("midrst_ready", monitor_ready, 1'b1);
    check("midrst_jpend", dut.jpend_q, 1'b0);
    check("midrst_MonDReg", MonDReg, 32'h0);
    check("midrst_MonAReg", dut.mon_a_q, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    avs_write = 1'b0;
    check("midrst_no_write", wr_count - wc0, 0);
    cpu_read(8'h05, 32'hDEADBEEF);
    cpu_read(8'h20, 32'h00000000);
    jwrite(8'h00, 32'h0BADF00D);
    check("postrst_MonAReg", dut.mon_a_q, 8'h01);
    jread(0, 8'h00, 32'h0BADF00D);

    check("wr_queue_empty", wq.size(), 0);
    check("rd_queue_empty", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
